// File: rtl/regfile_bank_32x32.sv
// rtl/regfile_bank_32x32.sv - 32 x DATA_W register bank, one handshaked write port, bulk-clear sequencer
module regfile_bank_32x32 #(
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [4:0]           wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 clr_req,
  output logic                 busy,
  output logic                 clr_done,
  output logic [32*DATA_W-1:0] q_flat
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t     state;
  logic [4:0] idx;
  logic       wr_fire;
  logic       clr_active;

  assign wr_ready   = (state == IDLE);
  assign busy       = (state == CLEAR);
  assign wr_fire    = wr_valid && wr_ready;
  assign clr_active = (state == CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 5'd1;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            idx   <= 5'd1;
          end
        end
        CLEAR: begin
          // idx is parked at 1 on exit so it never wraps through 0
          if (idx == 5'd31) begin
            state    <= IDLE;
            idx      <= 5'd1;
            clr_done <= 1'b1;
          end else begin
            idx <= idx + 5'd1;
          end
        end
        default: begin
          state <= IDLE;
          idx   <= 5'd1;
        end
      endcase
    end
  end

  assign q_flat[0 +: DATA_W] = '0;

  // Writes only fire in IDLE and clears only in CLEAR, so the two never collide.
  for (genvar k = 1; k < 32; k++) begin : g_reg
    logic [DATA_W-1:0] r;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r <= '0;
      end else if (clr_active && (idx == 5'(k))) begin
        r <= '0;
      end else if (wr_fire && (wr_addr == 5'(k))) begin
        r <= wr_data;
      end
    end

    assign q_flat[k*DATA_W +: DATA_W] = r;
  end

endmodule

// File: tb/tb_regfile_bank_32x32.sv
// tb/tb_regfile_bank_32x32.sv - directed self-checking bench for regfile_bank_32x32
module tb_regfile_bank_32x32;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [4:0]    wr_addr;
  logic [31:0]   wr_data;
  logic          clr_req;
  logic          busy;
  logic          clr_done;
  logic [1023:0] q_flat;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt;

  regfile_bank_32x32 #(.DATA_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_done (clr_done),
    .q_flat   (q_flat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sl(input int k);
    return q_flat[k*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic v, input logic [4:0] a, input logic [31:0] d);
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
  endtask

  initial begin
    rst = 1'b1;
    set_wr(1'b0, 5'd0, 32'h0);
    clr_req = 1'b0;
    tick();
    tick();
    chk("rst_q_any", {31'd0, |q_flat}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, wr_ready}, 32'd1);
    chk("rst_done", {31'd0, clr_done}, 32'd0);
    rst = 1'b0;

    // asynchronous reset after a write
    set_wr(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    set_wr(1'b0, 5'd0, 32'h0);
    chk("w5", sl(5), 32'hDEADBEEF);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_q5", sl(5), 32'h0);
    chk("async_rst_any", {31'd0, |q_flat}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_ready", {31'd0, wr_ready}, 32'd1);
    #1 rst = 1'b0;
    tick();

    // write / readback on consecutive cycles, no bypass
    set_wr(1'b1, 5'd1, 32'h11111111);
    chk("w1_ready", {31'd0, wr_ready}, 32'd1);
    chk("w1_nobypass", sl(1), 32'h0);
    tick();
    chk("w1", sl(1), 32'h11111111);
    set_wr(1'b1, 5'd31, 32'hFFFF0000);
    chk("w31_ready", {31'd0, wr_ready}, 32'd1);
    tick();
    chk("w31", sl(31), 32'hFFFF0000);
    set_wr(1'b1, 5'd0, 32'h12345678);
    chk("w0_ready", {31'd0, wr_ready}, 32'd1);
    tick();
    chk("w0_zero", sl(0), 32'h0);
    chk("w0_keep1", sl(1), 32'h11111111);
    set_wr(1'b0, 5'd0, 32'h0);

    // clear sequence over a fully loaded bank
    for (int k = 1; k < 32; k++) begin
      set_wr(1'b1, 5'(k), 32'(k));
      tick();
    end
    set_wr(1'b0, 5'd0, 32'h0);
    chk("load30", sl(30), 32'd30);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("clr_busy0", {31'd0, busy}, 32'd1);
    chk("clr_ready0", {31'd0, wr_ready}, 32'd0);
    for (int k = 1; k < 32; k++) begin
      tick();
      chk($sformatf("clr_r%0d", k), sl(k), 32'h0);
      if (k < 31) begin
        chk($sformatf("clr_keep%0d", k + 1), sl(k + 1), 32'(k + 1));
        chk($sformatf("clr_busy%0d", k), {31'd0, busy}, 32'd1);
        chk($sformatf("clr_ready%0d", k), {31'd0, wr_ready}, 32'd0);
        chk($sformatf("clr_done%0d", k), {31'd0, clr_done}, 32'd0);
      end
    end
    chk("clr_end_busy", {31'd0, busy}, 32'd0);
    chk("clr_end_done", {31'd0, clr_done}, 32'd1);
    chk("clr_end_ready", {31'd0, wr_ready}, 32'd1);
    tick();
    chk("clr_done_drop", {31'd0, clr_done}, 32'd0);

    // write held through a clear stalls until IDLE
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    set_wr(1'b1, 5'd7, 32'hA5A5A5A5);
    for (int c = 1; c <= 30; c++) tick();
    chk("stall_r7_n30", sl(7), 32'h0);
    chk("stall_ready_n30", {31'd0, wr_ready}, 32'd0);
    tick();
    chk("stall_ready_idle", {31'd0, wr_ready}, 32'd1);
    chk("stall_r7_idle", sl(7), 32'h0);
    tick();
    set_wr(1'b0, 5'd0, 32'h0);
    chk("stall_r7_land", sl(7), 32'hA5A5A5A5);

    // simultaneous write and clr_req, plus ignored re-pulse
    set_wr(1'b1, 5'd3, 32'h33);
    clr_req = 1'b1;
    tick();
    set_wr(1'b0, 5'd0, 32'h0);
    clr_req = 1'b0;
    chk("sim_r3_n0", sl(3), 32'h33);
    chk("sim_busy_n0", {31'd0, busy}, 32'd1);
    tick();
    chk("sim_r3_n1", sl(3), 32'h33);
    tick();
    chk("sim_r3_n2", sl(3), 32'h33);
    tick();
    chk("sim_r3_n3", sl(3), 32'h0);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 5; c <= 30; c++) tick();
    chk("repulse_busy_n30", {31'd0, busy}, 32'd1);
    chk("repulse_done_n30", {31'd0, clr_done}, 32'd0);
    tick();
    chk("repulse_done_n31", {31'd0, clr_done}, 32'd1);
    chk("repulse_busy_n31", {31'd0, busy}, 32'd0);
    tick();
    chk("repulse_busy_n32", {31'd0, busy}, 32'd0);
    chk("repulse_done_n32", {31'd0, clr_done}, 32'd0);

    // reset in the middle of a clear
    set_wr(1'b1, 5'd25, 32'h2525);
    tick();
    set_wr(1'b0, 5'd0, 32'h0);
    chk("mid_r25", sl(25), 32'h2525);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 1; c <= 10; c++) tick();
    chk("mid_busy_pre", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_r25", sl(25), 32'h0);
    chk("mid_rst_any", {31'd0, |q_flat}, 32'd0);
    chk("mid_rst_ready", {31'd0, wr_ready}, 32'd1);
    #1 rst = 1'b0;
    set_wr(1'b1, 5'd9, 32'h99);
    done_cnt = 0;
    tick();
    set_wr(1'b0, 5'd0, 32'h0);
    chk("post_rst_r9", sl(9), 32'h99);
    for (int c = 0; c < 25; c++) begin
      if (clr_done) done_cnt++;
      tick();
    end
    chk("post_rst_no_done", 32'(done_cnt), 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
